// File: rtl/dll_pkg.sv
// Shared types and sequence-number helpers for the DLL ACK/NAK receive path.
// Used by dll_acknak_scheduler and its sub-modules.
package dll_pkg;

  localparam int SEQ_W = 12;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACK_WAIT = 2'd1,
    SEND_ACK = 2'd2,
    SEND_NAK = 2'd3
  } dll_state_t;

  function automatic logic [SEQ_W-1:0] seq_diff(input logic [SEQ_W-1:0] a,
                                                input logic [SEQ_W-1:0] b);
    return a - b;
  endfunction

  // Duplicate when the TLP lies 1..half-range behind NEXT_RCV_SEQ.
  function automatic logic seq_in_dup_window(input logic [SEQ_W-1:0] next_seq,
                                             input logic [SEQ_W-1:0] seq);
    logic [SEQ_W-1:0] d;
    d = seq_diff(next_seq, seq);
    return (d != '0) && (d <= {1'b1, {(SEQ_W-1){1'b0}}});
  endfunction

endpackage

// File: rtl/dll_ack_timer.sv
// ACK coalescing latency counter: counts while enabled, flags expiry at
// LATENCY-1 and holds there until cleared.
module dll_ack_timer #(
  parameter int LATENCY = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  logic [CNT_W-1:0] count_reg;

  assign expire = enable && (count_reg == CNT_W'(LATENCY - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && !expire) begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/dll_acknak_scheduler.sv
// Receive-side ACK/NAK scheduler: checks TLP sequence numbers, tracks
// NEXT_RCV_SEQ and requests ACK/NAK DLLPs. DLL_ACK_COALESCE_EN enables ACK coalescing.
module dll_acknak_scheduler #(
  parameter int ACK_LATENCY = 32,
  parameter int SEQ_W       = dll_pkg::SEQ_W
) (
  input  logic             clk,
  input  logic             preset,
  input  logic             DL_up,
  input  logic             tlp_done_i,
  input  logic [SEQ_W-1:0] tlp_seq_i,
  input  logic             tlp_crc_ok_i,
  output logic             tlp_accept_o,
  output logic             dllp_valid_o,
  output logic             dllp_nak_o,
  output logic [SEQ_W-1:0] dllp_seq_o,
  input  logic             dllp_ready_i,
  output logic [SEQ_W-1:0] next_rcv_seq_o
);

  import dll_pkg::*;

  dll_state_t       state_reg, state_next;
  logic [SEQ_W-1:0] next_seq_reg, next_seq_next;
  logic [SEQ_W-1:0] dllp_seq_reg, dllp_seq_next;
  logic             nak_sched_reg, nak_sched_next;
  logic             ack_pending_reg, ack_pending_next;
  logic             nak_latch_reg, nak_latch_next;
  logic             dup_latch_reg, dup_latch_next;
  logic             accept_reg, accept_next;

  logic       done, good, dup, nak_req, in_send, handshake, timer_expire;
  dll_state_t ack_target;

  assign done      = DL_up && tlp_done_i;
  assign good      = done && tlp_crc_ok_i && (tlp_seq_i == next_seq_reg);
  assign dup       = done && tlp_crc_ok_i && seq_in_dup_window(next_seq_reg, tlp_seq_i);
  assign nak_req   = done && !good && !dup && !nak_sched_reg;
  assign in_send   = (state_reg == SEND_ACK) || (state_reg == SEND_NAK);
  assign handshake = in_send && dllp_ready_i;

  // A latency below one cycle cannot be represented by the timer.
  if (ACK_LATENCY < 1) begin : g_latency_invalid
  end

`ifdef DLL_ACK_COALESCE_EN
  assign ack_target = ACK_WAIT;

  dll_ack_timer #(
    .LATENCY(ACK_LATENCY)
  ) u_ack_timer (
    .clk    (clk),
    .rst    (preset),
    .clear  ((state_reg != ACK_WAIT) || !DL_up),
    .enable (state_reg == ACK_WAIT),
    .expire (timer_expire)
  );
`else
  assign ack_target   = SEND_ACK;
  assign timer_expire = 1'b0;
`endif

  always_comb begin
    state_next       = state_reg;
    next_seq_next    = next_seq_reg;
    nak_sched_next   = nak_sched_reg;
    dllp_seq_next    = dllp_seq_reg;
    accept_next      = good;
    ack_pending_next = 1'b0;
    nak_latch_next   = 1'b0;
    dup_latch_next   = 1'b0;

    if (good) begin
      next_seq_next  = next_seq_reg + 1'b1;
      nak_sched_next = 1'b0;
    end
    if (nak_req) begin
      nak_sched_next = 1'b1;
    end

    case (state_reg)
      IDLE, ACK_WAIT: begin
        if (nak_req) begin
          state_next = SEND_NAK;
        end else if (dup) begin
          state_next = SEND_ACK;
        end else if ((state_reg == ACK_WAIT) && timer_expire) begin
          state_next = SEND_ACK;
        end else if (good) begin
          state_next = ack_target;
        end
      end
      SEND_ACK, SEND_NAK: begin
        // Type and payload are frozen until the handshake; later events queue up.
        if (handshake) begin
          if (nak_req || nak_latch_reg) begin
            state_next = SEND_NAK;
          end else if (dup || dup_latch_reg) begin
            state_next = SEND_ACK;
          end else if (good || ack_pending_reg) begin
            state_next = ack_target;
          end else begin
            state_next = IDLE;
          end
        end else begin
          ack_pending_next = ack_pending_reg || good;
          nak_latch_next   = nak_latch_reg || nak_req;
          dup_latch_next   = dup_latch_reg || dup;
        end
      end
      default: state_next = IDLE;
    endcase

    // Payload tracks NEXT_RCV_SEQ-1 and is captured as a request starts.
    if (!in_send || handshake) begin
      dllp_seq_next = next_seq_next - 1'b1;
    end

    if (!DL_up) begin
      state_next       = IDLE;
      next_seq_next    = '0;
      nak_sched_next   = 1'b0;
      dllp_seq_next    = '1;
      accept_next      = 1'b0;
      ack_pending_next = 1'b0;
      nak_latch_next   = 1'b0;
      dup_latch_next   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge preset) begin
    if (preset) begin
      state_reg       <= IDLE;
      next_seq_reg    <= '0;
      dllp_seq_reg    <= '1;
      nak_sched_reg   <= 1'b0;
      ack_pending_reg <= 1'b0;
      nak_latch_reg   <= 1'b0;
      dup_latch_reg   <= 1'b0;
      accept_reg      <= 1'b0;
    end else begin
      state_reg       <= state_next;
      next_seq_reg    <= next_seq_next;
      dllp_seq_reg    <= dllp_seq_next;
      nak_sched_reg   <= nak_sched_next;
      ack_pending_reg <= ack_pending_next;
      nak_latch_reg   <= nak_latch_next;
      dup_latch_reg   <= dup_latch_next;
      accept_reg      <= accept_next;
    end
  end

  assign tlp_accept_o   = accept_reg;
  assign dllp_valid_o   = in_send;
  assign dllp_nak_o     = (state_reg == SEND_NAK);
  assign dllp_seq_o     = dllp_seq_reg;
  assign next_rcv_seq_o = next_seq_reg;

endmodule

// File: tb/tb_dll_acknak_scheduler.sv
// Self-checking bench for dll_acknak_scheduler: vector table for TLP
// receive steps, DLLP scoreboard queue, hand sequences for multi-cycle cases.
module tb_dll_acknak_scheduler;

  localparam int SEQ_W = 12;
  localparam int LAT   = 32;
`ifdef DLL_ACK_COALESCE_EN
  localparam bit COAL = 1'b1;
`else
  localparam bit COAL = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             preset = 1'b1;
  logic             DL_up = 1'b0;
  logic             tlp_done_i = 1'b0;
  logic [SEQ_W-1:0] tlp_seq_i = '0;
  logic             tlp_crc_ok_i = 1'b0;
  logic             dllp_ready_i = 1'b1;
  logic             tlp_accept_o, dllp_valid_o, dllp_nak_o;
  logic [SEQ_W-1:0] dllp_seq_o, next_rcv_seq_o;

  dll_acknak_scheduler #(.ACK_LATENCY(LAT), .SEQ_W(SEQ_W)) dut (
    .clk(clk), .preset(preset), .DL_up(DL_up),
    .tlp_done_i(tlp_done_i), .tlp_seq_i(tlp_seq_i), .tlp_crc_ok_i(tlp_crc_ok_i),
    .tlp_accept_o(tlp_accept_o), .dllp_valid_o(dllp_valid_o), .dllp_nak_o(dllp_nak_o),
    .dllp_seq_o(dllp_seq_o), .dllp_ready_i(dllp_ready_i), .next_rcv_seq_o(next_rcv_seq_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // DLLP scoreboard: expectations pushed with stimulus, popped on handshake.
  typedef struct packed { logic nak; logic [SEQ_W-1:0] seq; } dllp_t;
  dllp_t exp_q[$];
  bit sb_on = 1'b1;
  logic hold_reg = 1'b0, held_nak = 1'b0, prev_valid = 1'b0;
  logic [SEQ_W-1:0] held_seq = '0;
  int rise_cyc = 0;

  function automatic void exp_dllp(input logic nak, input logic [SEQ_W-1:0] seq);
    exp_q.push_back({nak, seq});
  endfunction

  always @(negedge clk) begin
    dllp_t e;
    if (dllp_valid_o && !prev_valid) rise_cyc = cyc;
    if (hold_reg && dllp_valid_o) begin
      chk("held dllp_nak stable", 32'(dllp_nak_o), 32'(held_nak));
      chk("held dllp_seq stable", 32'(dllp_seq_o), 32'(held_seq));
    end
    if (dllp_valid_o && dllp_ready_i && sb_on) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected dllp: got nak=%0d seq=%03h, expected none", dllp_nak_o, dllp_seq_o);
      end else begin
        e = exp_q.pop_front();
        chk("dllp type", 32'(dllp_nak_o), 32'(e.nak));
        chk("dllp seq", 32'(dllp_seq_o), 32'(e.seq));
      end
    end
    hold_reg   <= dllp_valid_o && !dllp_ready_i && !preset;
    held_nak   <= dllp_nak_o;
    held_seq   <= dllp_seq_o;
    prev_valid <= dllp_valid_o;
  end

  typedef struct {
    int               phase;
    logic             dl;
    logic [SEQ_W-1:0] seq;
    logic             ok;
    logic             acc;
    logic [SEQ_W-1:0] nxt;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(input int p, input logic dl, input logic [SEQ_W-1:0] s,
                              input logic ok, input logic acc, input logic [SEQ_W-1:0] n);
    vec_t v;
    v.phase = p; v.dl = dl; v.seq = s; v.ok = ok; v.acc = acc; v.nxt = n;
    vecs.push_back(v);
  endfunction

  // All tasks start and end 1 time unit after a rising edge.
  task automatic send(input logic [SEQ_W-1:0] seq, input logic ok, input logic exp_acc,
                      input logic [SEQ_W-1:0] exp_next, input string name);
    tlp_done_i = 1'b1; tlp_seq_i = seq; tlp_crc_ok_i = ok;
    @(posedge clk); #1;
    tlp_done_i = 1'b0;
    chk({name, " accept"}, 32'(tlp_accept_o), 32'(exp_acc));
    chk({name, " next_rcv_seq"}, 32'(next_rcv_seq_o), 32'(exp_next));
  endtask

  task automatic run_phase(input int p);
    foreach (vecs[i]) begin
      if (vecs[i].phase == p) begin
        DL_up = vecs[i].dl;
        send(vecs[i].seq, vecs[i].ok, vecs[i].acc, vecs[i].nxt,
             $sformatf("p%0d seq %03h", p, vecs[i].seq));
      end
    end
  endtask

  task automatic do_reset();
    preset = 1'b1; DL_up = 1'b0; tlp_done_i = 1'b0; dllp_ready_i = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    preset = 1'b0; DL_up = 1'b1;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!dllp_valid_o && n < 100) begin @(posedge clk); #1; n++; end
    chk({name, " valid"}, 32'(dllp_valid_o), 32'd1);
  endtask

  task automatic drain(input string name);
    int n = 0;
    repeat (40) @(posedge clk);
    #1;
    while ((dllp_valid_o || exp_q.size() != 0) && n < 200) begin @(posedge clk); #1; n++; end
    chk({name, " pending dllps"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    // phase 1/2: lost TLP then NAK suppression; 3: wrap + duplicate;
    // 4: DL_up low; 5: duplicate window boundary.
    add(1, 1'b1, 12'h000, 1'b1, 1'b1, 12'h001);
    add(1, 1'b1, 12'h002, 1'b1, 1'b0, 12'h001);
    add(2, 1'b1, 12'h003, 1'b0, 1'b0, 12'h001);
    add(2, 1'b1, 12'h001, 1'b1, 1'b1, 12'h002);
    add(2, 1'b1, 12'h005, 1'b1, 1'b0, 12'h002);
    add(3, 1'b1, 12'hFFF, 1'b1, 1'b1, 12'h000);
    add(3, 1'b1, 12'hFFF, 1'b1, 1'b0, 12'h000);
    add(4, 1'b0, 12'h001, 1'b1, 1'b0, 12'h000);
    add(4, 1'b0, 12'h000, 1'b1, 1'b0, 12'h000);
    add(5, 1'b1, 12'h000, 1'b1, 1'b1, 12'h001);
    add(5, 1'b1, 12'h001, 1'b1, 1'b1, 12'h002);
    add(5, 1'b1, 12'h002, 1'b1, 1'b1, 12'h003);
    add(5, 1'b1, 12'h803, 1'b1, 1'b0, 12'h003);
    add(5, 1'b1, 12'h802, 1'b1, 1'b0, 12'h003);

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("reset dllp_valid", 32'(dllp_valid_o), 32'd0);
    chk("reset dllp_nak", 32'(dllp_nak_o), 32'd0);
    chk("reset dllp_seq", 32'(dllp_seq_o), 32'hFFF);
    chk("reset next_rcv_seq", 32'(next_rcv_seq_o), 32'd0);
    chk("reset accept", 32'(tlp_accept_o), 32'd0);

    // Three in-order TLPs and ACK latency
    do_reset();
    if (COAL) exp_dllp(1'b0, 12'h002);
    else begin exp_dllp(1'b0, 12'h000); exp_dllp(1'b0, 12'h001); exp_dllp(1'b0, 12'h002); end
    send(12'h000, 1'b1, 1'b1, 12'h001, "A seq 000");
    t0 = cyc;
    chk("A ack valid right after accept", 32'(dllp_valid_o), 32'(!COAL));
    send(12'h001, 1'b1, 1'b1, 12'h002, "A seq 001");
    send(12'h002, 1'b1, 1'b1, 12'h003, "A seq 002");
    wait_valid("A ack");
    @(posedge clk); #1;
    chk("A ack latency", 32'(rise_cyc - t0), COAL ? 32'(LAT) : 32'd0);
    drain("A");

    // Lost TLP -> NAK; bad CRC while NAK scheduled -> nothing; recovery
    do_reset();
    if (COAL) begin
      exp_dllp(1'b1, 12'h000); exp_dllp(1'b1, 12'h001);
    end else begin
      exp_dllp(1'b0, 12'h000); exp_dllp(1'b1, 12'h000);
      exp_dllp(1'b0, 12'h001); exp_dllp(1'b1, 12'h001);
    end
    run_phase(1);
    run_phase(2);
    drain("BC");

    // Wrap of NEXT_RCV_SEQ and duplicate at the wrap point
    do_reset();
    sb_on = 1'b0;
    for (int s = 0; s < 4095; s++) begin
      tlp_done_i = 1'b1; tlp_seq_i = 12'(s); tlp_crc_ok_i = 1'b1;
      @(posedge clk); #1;
    end
    tlp_done_i = 1'b0;
    drain("D fill");
    chk("D next_rcv_seq before wrap", 32'(next_rcv_seq_o), 32'hFFF);
    sb_on = 1'b1;
    exp_dllp(1'b0, 12'hFFF);
    if (!COAL) exp_dllp(1'b0, 12'hFFF);
    run_phase(3);
    chk("D duplicate ack immediate", 32'(dllp_valid_o), 32'd1);
    chk("D duplicate ack seq", 32'(dllp_seq_o), 32'hFFF);
    drain("D");

    // NAK request while an ACK is stalled by dllp_ready_i = 0
    do_reset();
    dllp_ready_i = 1'b0;
    exp_dllp(1'b0, 12'h000); exp_dllp(1'b1, 12'h000);
    send(12'h000, 1'b1, 1'b1, 12'h001, "E seq 000");
    wait_valid("E ack");
    send(12'h005, 1'b1, 1'b0, 12'h001, "E seq 005");
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk("E stalled valid", 32'(dllp_valid_o), 32'd1);
      chk("E stalled type", 32'(dllp_nak_o), 32'd0);
      chk("E stalled seq", 32'(dllp_seq_o), 32'h000);
    end
    dllp_ready_i = 1'b1;
    @(posedge clk); #1;
    chk("E nak follows", 32'(dllp_nak_o & dllp_valid_o), 32'd1);
    drain("E");

    // DL_up drop while waiting to ACK
    do_reset();
    if (!COAL) exp_dllp(1'b0, 12'h000);
    send(12'h000, 1'b1, 1'b1, 12'h001, "F seq 000");
    repeat (5) @(posedge clk);
    #1;
    DL_up = 1'b0;
    @(posedge clk); #1;
    chk("F valid after DL_up drop", 32'(dllp_valid_o), 32'd0);
    chk("F next_rcv_seq after DL_up drop", 32'(next_rcv_seq_o), 32'd0);
    chk("F dllp_seq after DL_up drop", 32'(dllp_seq_o), 32'hFFF);
    run_phase(4);
    DL_up = 1'b1;
    drain("F");

    // Duplicate window boundary: distance 2048 is a duplicate, 2049 is lost
    do_reset();
    if (COAL) begin
      exp_dllp(1'b0, 12'h002); exp_dllp(1'b1, 12'h002);
    end else begin
      exp_dllp(1'b0, 12'h000); exp_dllp(1'b0, 12'h001); exp_dllp(1'b0, 12'h002);
      exp_dllp(1'b0, 12'h002); exp_dllp(1'b1, 12'h002);
    end
    run_phase(5);
    drain("G");

    // Reset during a stalled request abandons it
    do_reset();
    dllp_ready_i = 1'b0;
    send(12'h000, 1'b1, 1'b1, 12'h001, "H seq 000");
    wait_valid("H ack");
    preset = 1'b1;
    #1;
    chk("H valid during preset", 32'(dllp_valid_o), 32'd0);
    @(posedge clk); #1;
    dllp_ready_i = 1'b1;
    preset = 1'b0;
    drain("H");
    chk("H next_rcv_seq after preset", 32'(next_rcv_seq_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dll_acknak_scheduler.md
DLL_ACKNAK_SCHEDULER -- requirements
Module: dll_acknak_scheduler

Interface
REQ-001 SHALL have parameter ACK_LATENCY, default 32, ACK coalescing timeout in clk cycles.
REQ-002 SHALL have parameter SEQ_W, default 12, sequence-number width.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port preset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port DL_up, input, 1, link up from the DLCMSM.
REQ-006 SHALL have port tlp_done_i, input, 1, one-cycle pulse from the decoder when a received TLP's LCRC check completes.
REQ-007 SHALL have port tlp_seq_i, input, SEQ_W, sequence number of that TLP.
REQ-008 SHALL have port tlp_crc_ok_i, input, 1, LCRC match for that TLP.
REQ-009 SHALL have port tlp_accept_o, output, 1, one-cycle pulse telling the decoder to forward the TLP to the TL (0 = discard).
REQ-010 SHALL have port dllp_valid_o, output, 1, ACK/NAK DLLP request to the TX DLLP builder.
REQ-011 SHALL have port dllp_nak_o, output, 1, DLLP type (0 = ACK, 1 = NAK).
REQ-012 SHALL have port dllp_seq_o, output, SEQ_W, AckNak_Seq_Num.
REQ-013 SHALL have port dllp_ready_i, input, 1, TX builder accepts the request.
REQ-014 SHALL have port next_rcv_seq_o, output, SEQ_W, current NEXT_RCV_SEQ for debug.

Function
REQ-015 SHALL give tlp_accept_o one cycle of latency after tlp_done_i.
REQ-016 SHALL, on tlp_done_i with crc_ok and seq == NEXT_RCV_SEQ: pulse accept, increment NEXT_RCV_SEQ mod 2^SEQ_W, clear NAK_SCHEDULED, and set ack_pending.
REQ-017 SHALL, on crc_ok with (NEXT_RCV_SEQ - seq) mod 4096 in 1..2048 (duplicate): discard and request an ACK immediately, bypassing the timer.
REQ-018 SHALL, on crc_ok with any other seq (lost TLP), or on crc_ok = 0: discard and, if NAK_SCHEDULED = 0, set NAK_SCHEDULED and request a NAK; if NAK_SCHEDULED = 1, no new request is made.
REQ-019 SHALL always drive dllp_seq_o with (NEXT_RCV_SEQ - 1) mod 2^SEQ_W, sampled when dllp_valid_o rises.
REQ-020 SHALL use FSM states IDLE, ACK_WAIT, SEND_ACK and SEND_NAK.
REQ-021 SHALL implement FSM transitions IDLE->ACK_WAIT on accept; ACK_WAIT->SEND_ACK when timer == ACK_LATENCY-1; any->SEND_NAK on a NAK request; IDLE/ACK_WAIT->SEND_ACK on a duplicate.
REQ-022 SHALL, in SEND_* with dllp_valid_o = 1, hold dllp_nak_o and dllp_seq_o stable until dllp_valid_o && dllp_ready_i, then go to IDLE, or to ACK_WAIT if ack_pending was set again during the wait.
REQ-023 SHALL, while in SEND_ACK with valid asserted, latch a NAK request and enter SEND_NAK right after the handshake; it SHALL NOT change the type mid-request.
REQ-024 SHALL clear the timer and ack_pending on any completed handshake, since a NAK also acknowledges NEXT_RCV_SEQ-1.
REQ-025 SHALL, while DL_up = 0: ignore tlp_done_i, hold tlp_accept_o = 0, and synchronously return all state to reset values.

Reset
REQ-026 SHALL, on preset: FSM = IDLE, NEXT_RCV_SEQ = 0, NAK_SCHEDULED = 0, timer = 0, tlp_accept_o = 0, dllp_valid_o = 0, dllp_nak_o = 0, dllp_seq_o = 0xFFF.
REQ-027 SHALL abandon any request in flight when preset asserts mid-handshake, with no further handshake completing.

Configuration
REQ-028 SHALL, with DLL_ACK_COALESCE_EN defined, coalesce ACKs using the ACK_LATENCY timer.
REQ-029 SHALL, without DLL_ACK_COALESCE_EN, omit ACK_WAIT and the timer and go to SEND_ACK the cycle after every accept.

Structure
REQ-030 SHALL place dll_state_t, SEQ_W, and the seq_diff/seq_in_dup_window functions in shared package dll_pkg.
REQ-031 SHALL place the latency counter in sub-module dll_ack_timer (clear, enable, expire).

Verification
REQ-032 SHALL test: seq 0,1,2 good, ACK_LATENCY = 32 -> three accepts, one ACK with seq 2, 32 cycles after the first accept.
REQ-033 SHALL test: seq 0 good, then seq 2 good -> seq 2 discarded, NAK with seq 0, NAK_SCHEDULED = 1.
REQ-034 SHALL test: after a NAK, seq 3 with crc_ok = 0 -> discarded, no second NAK; then seq 1 good -> accept, NAK_SCHEDULED cleared.
REQ-035 SHALL test: NEXT_RCV_SEQ = 0xFFF, seq 0xFFF good -> NEXT_RCV_SEQ wraps to 0x000; a duplicate seq 0xFFF -> immediate ACK with seq 0xFFF.
REQ-036 SHALL test: dllp_ready_i held 0 for 10 cycles while a NAK request arrives during SEND_ACK -> ACK payload stays stable, then NAK follows.
REQ-037 SHALL test: DL_up dropped mid-ACK_WAIT -> valid = 0, NEXT_RCV_SEQ = 0, and a tlp_done_i in that window produces no accept.
